gps_code_capture: RTL and testbench
===================================

Name: gps_code_capture

Overview:
- Downstream consumer of the GPS mock-TSS core outputs (ca_code, p_code, l_code, l_code_valid).
- Detects each completed code round, snapshots the three code words with a sequence number and a start-to-valid latency count, and buffers the records in a first-word-fall-through (FWFT) FIFO.
- Software reads records through the register layer via a pop handshake.
- Gives software lossless access to every round's codes even when rounds complete faster than software polls.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- LAT_W, 32, width of the latency counter and stored latency field.
- SEQ_W, 16, width of the round sequence number.

Ports:
- sys_clk_50  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_round  in  1  same startRound pulse driven to the GPS core.
- ca_code  in  13  C/A code from the mock-TSS wrapper.
- p_code  in  128  P code from the mock-TSS wrapper.
- l_code  in  128  L code from the mock-TSS wrapper.
- l_code_valid  in  1  level; high while the current round's codes are valid.
- rd_pop  in  1  pulse; consume the head record.
- clear  in  1  pulse; synchronous flush of FIFO, counters and flags.
- rd_valid  out  1  head record present.
- rd_ca  out  13  head C/A code.
- rd_p  out  128  head P code.
- rd_l  out  128  head L code.
- rd_seq  out  SEQ_W  head sequence number.
- rd_latency  out  LAT_W  head start-to-valid cycle count.
- fifo_count  out  clog2(DEPTH)+1  records held.
- overflow  out  1  sticky; a capture was dropped because the FIFO was full.
- timeout_cnt  out  8  saturating count of start_round pulses that arrived while a round was still pending.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty; all outputs 0; FSM in IDLE; seq=0; latency counter=0.
- Capture event: rising edge of l_code_valid, i.e. prev=0 and cur=1, using a registered previous value. A level held high captures exactly once.
- Captured record = {ca_code, p_code, l_code, seq, latency}, sampled in the same cycle the edge is detected.
- seq increments by 1 per capture attempt, including dropped ones, and wraps at 2^SEQ_W.
- Latency FSM:
  - IDLE: on start_round, latency=0 and go to RUN.
  - RUN: latency increments each cycle, saturating at all-ones.
  - RUN, capture edge: the record takes the current latency value; go to IDLE.
  - RUN, start_round again before a capture: timeout_cnt+1 (saturating at 255); latency restarts at 0; stay in RUN.
  - RUN, start_round and capture edge in the same cycle: the capture uses the old latency; then latency=0 and stay in RUN.
  - Capture edge while IDLE (no start seen): the record stores latency = all-ones.
- FIFO:
  - FWFT: rd_* shows the head whenever rd_valid=1.
  - Push latency: edge detected in cycle N -> rd_valid=1 in N+1 if the FIFO was empty.
  - rd_pop with rd_valid=1 removes the head; the next entry is visible the following cycle.
  - rd_pop while empty is ignored; no underflow, count unchanged.
  - Full and capture without pop: record dropped, overflow<=1, FIFO unchanged.
  - Full and capture with rd_pop in the same cycle: both occur; no drop; count unchanged.
  - Empty and capture with rd_pop in the same cycle: the pop is ignored; push occurs.
  - rd_* holds its value when rd_valid=0; the value is don't-care but must not be X after reset.
- Pointers wrap modulo DEPTH; count is tracked separately so full (count==DEPTH) and empty are distinguished.
- clear:
  - Empties the FIFO; zeroes seq, overflow, timeout_cnt and latency; FSM to IDLE.
  - Has priority over a same-cycle capture or pop; that capture is discarded.
  - The edge-detect register still updates, so a held-high l_code_valid is not recaptured after clear.
- Mid-operation reset: everything returns to reset values asynchronously; resumes cleanly after deassertion. A level l_code_valid high at deassertion is not captured, because prev initialises to 0 only on the first sample — see test 5.
  - Correction, decided: prev resets to 1, so a level already high at reset release never produces a capture.

Test Plan:
1. Reset release, start_round, l_code_valid rises 40 cycles later with ca=13'h1A5, p=128'hA5.., l=128'h5A.. -> next cycle rd_valid=1, rd_ca=13'h1A5, rd_seq=0, rd_latency=40, fifo_count=1; rd_pop -> rd_valid=0, count=0.
2. Five rounds with no pop, DEPTH=4 -> fifo_count=4, overflow=1, popped seq order 0,1,2,3; fifth record absent; next capture gets seq=5.
3. FIFO full, capture edge and rd_pop in the same cycle -> count stays 4, overflow stays 0, tail holds the new record.
4. Two start_round pulses 10 cycles apart, then valid 7 cycles after the second -> timeout_cnt=1, rd_latency=7; capture with no prior start -> rd_latency=32'hFFFFFFFF.
5. l_code_valid held high 100 cycles -> exactly one record. rst_n pulsed low mid-hold -> all outputs 0 immediately; no capture after release while the level stays high.
6. clear asserted in the same cycle as a capture edge with 2 records queued -> fifo_count=0, rd_valid=0, seq=0, overflow=0; no record from that edge.

Source files
------------

// File: rtl/gps_code_capture.sv
// Snapshots the GPS core's code words on each completed round and queues them, with a
// sequence number and start-to-valid latency, in a first-word-fall-through FIFO for software.
module gps_code_capture #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT_W = 32,
  parameter int unsigned SEQ_W = 16
) (
  input  logic                       sys_clk_50,
  input  logic                       rst_n,
  input  logic                       start_round,
  input  logic [12:0]                ca_code,
  input  logic [127:0]               p_code,
  input  logic [127:0]               l_code,
  input  logic                       l_code_valid,
  input  logic                       rd_pop,
  input  logic                       clear,
  output logic                       rd_valid,
  output logic [12:0]                rd_ca,
  output logic [127:0]               rd_p,
  output logic [127:0]               rd_l,
  output logic [SEQ_W-1:0]           rd_seq,
  output logic [LAT_W-1:0]           rd_latency,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [7:0]                 timeout_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [SEQ_W-1:0] SeqOne = SEQ_W'(1);
  localparam logic [LAT_W-1:0] LatOne = LAT_W'(1);
  localparam logic [PtrW-1:0]  PtrOne = PtrW'(1);
  localparam logic [CntW-1:0]  CntOne = CntW'(1);
  localparam logic [CntW-1:0]  CntFull = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic [LAT_W-1:0]  lat_q;
  logic [7:0]        timeout_q;
  logic              prev_q;
  logic [SEQ_W-1:0]  seq_q;
  logic              overflow_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic [12:0]       ca_mem  [DEPTH];
  logic [127:0]      p_mem   [DEPTH];
  logic [127:0]      l_mem   [DEPTH];
  logic [SEQ_W-1:0]  seq_mem [DEPTH];
  logic [LAT_W-1:0]  lat_mem [DEPTH];

  logic              cap;
  logic [LAT_W-1:0]  lat_inc;
  logic [LAT_W-1:0]  cap_lat;
  logic              full;
  logic              empty;
  logic              do_pop;
  logic              do_push;
  logic              drop;

  always_comb begin
    cap     = l_code_valid & ~prev_q;
    lat_inc = (lat_q == '1) ? lat_q : lat_q + LatOne;
    // The recorded latency counts the capture cycle itself, i.e. cycles elapsed since start.
    cap_lat = (state_q == StRun) ? lat_inc : '1;
    full    = (count_q == CntFull);
    empty   = (count_q == '0);
    do_pop  = rd_pop & ~empty & ~clear;
    do_push = cap & ~clear & (~full | do_pop);
    drop    = cap & ~clear & full & ~do_pop;
  end

  // Latency FSM
  always_ff @(posedge sys_clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lat_q     <= '0;
      timeout_q <= '0;
    end else if (clear) begin
      state_q   <= StIdle;
      lat_q     <= '0;
      timeout_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_round) begin
            lat_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (start_round) begin
            lat_q <= '0;
            if (!cap && timeout_q != 8'hFF) timeout_q <= timeout_q + 8'd1;
          end else if (cap) begin
            state_q <= StIdle;
          end else begin
            lat_q <= lat_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // prev resets high so a level already asserted at reset release is never captured;
  // it also keeps updating during clear so a held level is not recaptured afterwards.
  always_ff @(posedge sys_clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= 1'b1;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      prev_q <= l_code_valid;
      if (clear) begin
        seq_q      <= '0;
        overflow_q <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (cap)     seq_q      <= seq_q + SeqOne;
        if (drop)    overflow_q <= 1'b1;
        if (do_push) wr_ptr_q   <= wr_ptr_q + PtrOne;
        if (do_pop)  rd_ptr_q   <= rd_ptr_q + PtrOne;
        if (do_push && !do_pop)      count_q <= count_q + CntOne;
        else if (do_pop && !do_push) count_q <= count_q - CntOne;
      end
    end
  end

  // Storage is reset so the head outputs are never X, even before the first push.
  always_ff @(posedge sys_clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ca_mem[i]  <= '0;
        p_mem[i]   <= '0;
        l_mem[i]   <= '0;
        seq_mem[i] <= '0;
        lat_mem[i] <= '0;
      end
    end else if (do_push) begin
      ca_mem[wr_ptr_q]  <= ca_code;
      p_mem[wr_ptr_q]   <= p_code;
      l_mem[wr_ptr_q]   <= l_code;
      seq_mem[wr_ptr_q] <= seq_q;
      lat_mem[wr_ptr_q] <= cap_lat;
    end
  end

  always_comb begin
    rd_valid    = ~empty;
    rd_ca       = ca_mem[rd_ptr_q];
    rd_p        = p_mem[rd_ptr_q];
    rd_l        = l_mem[rd_ptr_q];
    rd_seq      = seq_mem[rd_ptr_q];
    rd_latency  = lat_mem[rd_ptr_q];
    fifo_count  = count_q;
    overflow    = overflow_q;
    timeout_cnt = timeout_q;
  end

endmodule

// File: tb/tb_gps_code_capture.sv
// Directed bench for gps_code_capture: a queue-based model of the capture/FIFO rules is
// compared every cycle, plus literal expectations from hand-computed scenarios.
module tb_gps_code_capture;

  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_round = 1'b0;
  logic [12:0]   ca_code = '0;
  logic [127:0]  p_code = '0;
  logic [127:0]  l_code = '0;
  logic          l_code_valid = 1'b0;
  logic          rd_pop = 1'b0;
  logic          clear = 1'b0;
  logic          rd_valid;
  logic [12:0]   rd_ca;
  logic [127:0]  rd_p;
  logic [127:0]  rd_l;
  logic [15:0]   rd_seq;
  logic [31:0]   rd_latency;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic [7:0]    timeout_cnt;

  int checks = 0;
  int failures = 0;

  gps_code_capture #(.DEPTH(DEPTH), .LAT_W(32), .SEQ_W(16)) dut (
    .sys_clk_50   (clk),
    .rst_n        (rst_n),
    .start_round  (start_round),
    .ca_code      (ca_code),
    .p_code       (p_code),
    .l_code       (l_code),
    .l_code_valid (l_code_valid),
    .rd_pop       (rd_pop),
    .clear        (clear),
    .rd_valid     (rd_valid),
    .rd_ca        (rd_ca),
    .rd_p         (rd_p),
    .rd_l         (rd_l),
    .rd_seq       (rd_seq),
    .rd_latency   (rd_latency),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .timeout_cnt  (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: records as a queue; latency is cycles elapsed since the pending start_round.
  typedef struct {
    logic [12:0]  ca;
    logic [127:0] p;
    logic [127:0] l;
    logic [15:0]  seq;
    logic [31:0]  lat;
  } rec_t;

  rec_t        mq[$];
  logic [15:0] m_seq = '0;
  bit          m_ovf = 0;
  int          m_tmo = 0;
  bit          m_pend = 0;
  bit          m_prev = 1;
  longint      m_cyc = 0;
  longint      m_start = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_seq = '0; m_ovf = 0; m_tmo = 0; m_pend = 0; m_prev = 1;
      end else begin
        bit     cap;
        bit     popped;
        int     n;
        rec_t   r;
        longint el;
        m_cyc++;
        cap = l_code_valid && !m_prev;
        m_prev = l_code_valid;
        if (clear) begin
          mq.delete();
          m_seq = '0; m_ovf = 0; m_tmo = 0; m_pend = 0;
        end else begin
          n = mq.size();
          popped = rd_pop && n > 0;
          if (popped) void'(mq.pop_front());
          if (cap) begin
            el = m_cyc - m_start;
            r.ca = ca_code; r.p = p_code; r.l = l_code; r.seq = m_seq;
            r.lat = !m_pend ? 32'hFFFF_FFFF : (el > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : el[31:0]);
            m_seq = m_seq + 16'd1;
            if (n < DEPTH || popped) mq.push_back(r);
            else m_ovf = 1;
          end
          if (start_round && m_pend && !cap && m_tmo < 255) m_tmo++;
          if (start_round) begin
            m_pend = 1;
            m_start = m_cyc;
          end else if (cap) begin
            m_pend = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("m_valid", rd_valid, mq.size() > 0);
      check("m_count", fifo_count, mq.size());
      check("m_overflow", overflow, m_ovf);
      check("m_timeout", timeout_cnt, m_tmo);
      if (mq.size() > 0) begin
        check("m_ca", rd_ca, mq[0].ca);
        check("m_p", rd_p, mq[0].p);
        check("m_l", rd_l, mq[0].l);
        check("m_seq", rd_seq, mq[0].seq);
        check("m_lat", rd_latency, mq[0].lat);
      end
    end
  end

  task automatic set_codes(input int i);
    ca_code = 13'h0A0 + 13'(i);
    p_code  = {4{32'hA5A5_A5A5}} ^ 128'(i);
    l_code  = {4{32'h5A5A_5A5A}} ^ (128'(i) << 64);
  endtask

  task automatic capture(input int i);
    set_codes(i);
    l_code_valid = 1'b1;
    @(negedge clk);
    l_code_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop();
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ca", rd_ca, 0);
    check("rst_latency", rd_latency, 0);
    check("rst_timeout", timeout_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: start, valid 40 cycles later
    start_round = 1'b1;
    @(negedge clk);
    start_round = 1'b0;
    repeat (39) @(negedge clk);
    ca_code = 13'h1A5;
    p_code  = {16{8'hA5}};
    l_code  = {16{8'h5A}};
    l_code_valid = 1'b1;
    @(negedge clk);
    l_code_valid = 1'b0;
    check("t1_valid", rd_valid, 1);
    check("t1_ca", rd_ca, 13'h1A5);
    check("t1_p", rd_p, {16{8'hA5}});
    check("t1_seq", rd_seq, 0);
    check("t1_latency", rd_latency, 40);
    check("t1_count", fifo_count, 1);
    pop();
    check("t1_pop_valid", rd_valid, 0);
    check("t1_pop_count", fifo_count, 0);

    // 2: five captures into a 4-deep FIFO
    do_clear();
    for (int i = 0; i < 5; i++) capture(i);
    check("t2_count", fifo_count, 4);
    check("t2_overflow", overflow, 1);
    check("t2_idle_lat", rd_latency, 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      check("t2_seq_order", rd_seq, k);
      pop();
    end
    check("t2_empty", rd_valid, 0);
    capture(9);
    check("t2_next_seq", rd_seq, 5);
    pop();

    // 3: full, capture and pop together
    do_clear();
    for (int i = 0; i < 4; i++) capture(i + 20);
    set_codes(77);
    l_code_valid = 1'b1;
    rd_pop = 1'b1;
    @(negedge clk);
    l_code_valid = 1'b0;
    rd_pop = 1'b0;
    check("t3_count", fifo_count, 4);
    check("t3_overflow", overflow, 0);
    check("t3_head_seq", rd_seq, 1);
    repeat (3) pop();
    check("t3_tail_seq", rd_seq, 4);
    check("t3_tail_ca", rd_ca, 13'h0A0 + 13'd77);
    do_clear();

    // 4: double start, then idle capture
    start_round = 1'b1;
    @(negedge clk);
    start_round = 1'b0;
    repeat (9) @(negedge clk);
    start_round = 1'b1;
    @(negedge clk);
    start_round = 1'b0;
    repeat (6) @(negedge clk);
    capture(30);
    check("t4_timeout", timeout_cnt, 1);
    check("t4_latency", rd_latency, 7);
    pop();
    capture(31);
    check("t4_idle_latency", rd_latency, 32'hFFFF_FFFF);
    pop();

    // 5: held level, then reset during the hold
    set_codes(40);
    l_code_valid = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_one_record", fifo_count, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", rd_valid, 0);
    check("t5_rst_count", fifo_count, 0);
    check("t5_rst_seq", rd_seq, 0);
    check("t5_rst_timeout", timeout_cnt, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_no_recapture", fifo_count, 0);
    l_code_valid = 1'b0;
    @(negedge clk);

    // 6: clear coincident with a capture edge
    capture(50);
    capture(51);
    check("t6_pre_count", fifo_count, 2);
    set_codes(52);
    l_code_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t6_count", fifo_count, 0);
    check("t6_valid", rd_valid, 0);
    check("t6_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    check("t6_held_count", fifo_count, 0);
    l_code_valid = 1'b0;
    @(negedge clk);
    capture(53);
    check("t6_seq_reset", rd_seq, 0);
    check("t6_after_count", fifo_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
